// File: rtl/red_pitaya_pwm_dac_pkg.sv
// Shared constants and the threshold helper for the PWM DAC block.
package red_pitaya_pwm_dac_pkg;

    localparam int PWM_CNT_W = 8;
    localparam int PWM_PER_W = 4;
    localparam int PWM_CFG_W = 24;
    localparam int PWM_V_MSB = 23;
    localparam int PWM_V_LSB = 16;
    localparam int PWM_B_W   = 16;
    localparam int PWM_THR_W = PWM_CNT_W + 1;

    // Threshold = base duty plus the dither bit selected by the current period.
    // One extra bit keeps v=255 with a set dither bit at 256, above every count.
    function automatic logic [PWM_THR_W-1:0] pwm_thr(
        input logic [PWM_CFG_W-1:0] shadow,
        input logic [PWM_PER_W-1:0] per
    );
        logic [PWM_B_W-1:0]   b;
        logic [PWM_CNT_W-1:0] v;
        b = shadow[PWM_B_W-1:0];
        v = shadow[PWM_V_MSB:PWM_V_LSB];
        return {1'b0, v} + {{PWM_CNT_W{1'b0}}, b[per]};
    endfunction

endpackage

// File: rtl/red_pitaya_pwm_ch.sv
// One PWM channel: config shadow, dithered threshold and registered comparator.
module red_pitaya_pwm_ch
    import red_pitaya_pwm_dac_pkg::*;
#(
    parameter int CFG_W = PWM_CFG_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 run_i,
    input  logic                 load_i,
    input  logic [CFG_W-1:0]     cfg_i,
    input  logic [PWM_CNT_W-1:0] cnt_i,
    input  logic [PWM_PER_W-1:0] per_i,
    output logic                 pwm_o
);

    logic [CFG_W-1:0]     shadow_r;
    logic [PWM_THR_W-1:0] thr_s;
    logic                 pwm_r;

    // Threshold for the current period, taken from the shadow only.
    always_comb begin
        thr_s = pwm_thr(shadow_r[PWM_CFG_W-1:0], per_i);
    end

    // Shadow capture; the top decides when (reset, idle, or frame boundary).
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            shadow_r <= cfg_i;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Output flop: high while the count is below the threshold, forced low when stopped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_r <= 1'b0;
        end else if (run_i) begin
            pwm_r <= ({1'b0, cnt_i} < thr_s);
        end else begin
            pwm_r <= 1'b0;
        end
    end

    assign pwm_o = pwm_r;

endmodule

// File: rtl/red_pitaya_pwm_dac.sv
// Multi-channel dithered PWM DAC: shared cycle/period counters, frame-aligned
// config reload, and one red_pitaya_pwm_ch per output.
module red_pitaya_pwm_dac
    import red_pitaya_pwm_dac_pkg::*;
#(
    parameter int CHN   = 4,
    parameter int CFG_W = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [CHN*CFG_W-1:0] cfg_i,
    output logic [CHN-1:0]       pwm_o,
    output logic                 frame_o
);

    logic [PWM_CNT_W-1:0] cnt_r;
    logic [PWM_PER_W-1:0] per_r;
    logic                 frame_r;
    logic                 wrap_s;
    logic                 frame_end_s;
    logic                 load_s;

    // Frame boundary decode and shadow load strobe; shadows track cfg_i while stopped.
    always_comb begin
        wrap_s      = (cnt_r == 8'd255);
        frame_end_s = wrap_s && (per_r == 4'd15);
        load_s      = rst_i || !en_i || frame_end_s;
    end

    // Cycle and period counters plus the frame pulse; reset and idle hold everything at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r   <= 8'd0;
            per_r   <= 4'd0;
            frame_r <= 1'b0;
        end else if (en_i) begin
            cnt_r   <= cnt_r + 8'd1;
            per_r   <= wrap_s ? per_r + 4'd1 : per_r;
            frame_r <= frame_end_s;
        end else begin
            cnt_r   <= 8'd0;
            per_r   <= 4'd0;
            frame_r <= 1'b0;
        end
    end

    assign frame_o = frame_r;

    for (genvar n = 0; n < CHN; n++) begin : g_ch
        red_pitaya_pwm_ch #(
            .CFG_W (CFG_W)
        ) u_ch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .run_i  (en_i),
            .load_i (load_s),
            .cfg_i  (cfg_i[n*CFG_W +: CFG_W]),
            .cnt_i  (cnt_r),
            .per_i  (per_r),
            .pwm_o  (pwm_o[n])
        );
    end

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// Directed self-checking bench for red_pitaya_pwm_dac (4 channels).
module tb_red_pitaya_pwm_dac;

    logic        clk_i;
    logic        rst_i;
    logic        en_i;
    logic [95:0] cfg_i;
    logic [3:0]  pwm_o;
    logic        frame_o;

    int checks_cnt;
    int fail_cnt;

    // Statistics of the current observation window.
    int   pos;
    int   hi_cnt [4];
    int   per_hi [4][16];
    int   fr_cnt;
    logic fr_first;
    logic fr_last;
    logic pwm0_first;
    logic pwm0_at128;

    red_pitaya_pwm_dac #(
        .CHN   (4),
        .CFG_W (24)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .cfg_i   (cfg_i),
        .pwm_o   (pwm_o),
        .frame_o (frame_o)
    );

    // Free-running clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [23:0] c3, input logic [23:0] c2,
                           input logic [23:0] c1, input logic [23:0] c0);
        cfg_i = {c3, c2, c1, c0};
    endtask

    task automatic clear_stats();
        pos        = 0;
        fr_cnt     = 0;
        fr_first   = 1'b0;
        fr_last    = 1'b0;
        pwm0_first = 1'b0;
        pwm0_at128 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            hi_cnt[c] = 0;
            for (int p = 0; p < 16; p++) per_hi[c][p] = 0;
        end
    endtask

    // Advance n clocks, sampling outputs 1 time unit after each rising edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            for (int c = 0; c < 4; c++) begin
                if (pwm_o[c]) begin
                    hi_cnt[c]++;
                    per_hi[c][(pos >> 8) & 15]++;
                end
            end
            if (frame_o) fr_cnt++;
            if (pos == 0) begin
                fr_first   = frame_o;
                pwm0_first = pwm_o[0];
            end
            if (pos == 128)  pwm0_at128 = pwm_o[0];
            if (pos == 4095) fr_last    = frame_o;
            pos++;
        end
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_i      = 1'b1;
        en_i       = 1'b0;
        set_cfg(24'hFF_FFFF, 24'h00_0000, 24'h40_5555, 24'h80_0000);
        clear_stats();

        // Reset state.
        run_cycles(3);
        check_val("rst_pwm", {28'd0, pwm_o}, 32'd0);
        check_val("rst_frame", {31'd0, frame_o}, 32'd0);

        // Idle with en_i low.
        rst_i = 1'b0;
        run_cycles(2);
        check_val("idle_pwm", {28'd0, pwm_o}, 32'd0);

        // Frame A; cfg for frame B written mid-frame at per=7, cnt=100.
        en_i = 1'b1;
        clear_stats();
        run_cycles(1892);
        set_cfg(24'hFF_FFFF, 24'h01_8001, 24'hFF_0000, 24'h10_0000);
        run_cycles(2204);
        check_val("A_ch0_frame", hi_cnt[0], 32'd2048);
        check_val("A_ch0_per0", per_hi[0][0], 32'd128);
        check_val("A_ch0_first", {31'd0, pwm0_first}, 32'd1);
        check_val("A_ch0_at128", {31'd0, pwm0_at128}, 32'd0);
        check_val("A_ch1_frame", hi_cnt[1], 32'd1032);
        check_val("A_ch1_per0", per_hi[1][0], 32'd65);
        check_val("A_ch1_per1", per_hi[1][1], 32'd64);
        check_val("A_ch2_frame", hi_cnt[2], 32'd0);
        check_val("A_ch3_frame", hi_cnt[3], 32'd4096);
        check_val("A_fr_first", {31'd0, fr_first}, 32'd0);
        check_val("A_fr_cnt", fr_cnt, 32'd1);
        check_val("A_fr_last", {31'd0, fr_last}, 32'd1);

        // Frame B: old ch0 duty (16/period) holds despite the change at per=7, cnt=100.
        clear_stats();
        run_cycles(1892);
        set_cfg(24'hFF_FFFF, 24'h01_8001, 24'hFF_0000, 24'h20_0000);
        run_cycles(2204);
        check_val("B_ch0_frame", hi_cnt[0], 32'd256);
        check_val("B_ch0_per15", per_hi[0][15], 32'd16);
        check_val("B_ch1_per0", per_hi[1][0], 32'd255);
        check_val("B_ch1_frame", hi_cnt[1], 32'd4080);
        check_val("B_ch2_frame", hi_cnt[2], 32'd18);
        check_val("B_fr_cnt", fr_cnt, 32'd1);

        // Frame C: new ch0 duty; ch1 changed in the very reload cycle.
        clear_stats();
        run_cycles(4095);
        set_cfg(24'hFF_FFFF, 24'h01_8001, 24'h08_000F, 24'h20_0000);
        run_cycles(1);
        check_val("C_ch0_frame", hi_cnt[0], 32'd512);
        check_val("C_ch0_per5", per_hi[0][5], 32'd32);
        check_val("C_ch1_frame", hi_cnt[1], 32'd4080);
        check_val("C_fr_last", {31'd0, fr_last}, 32'd1);

        // Frame D: reload-cycle change captured; then en_i dropped at per=3.
        clear_stats();
        run_cycles(778);
        check_val("D_ch1_per0", per_hi[1][0], 32'd9);
        check_val("D_ch1_per2", per_hi[1][2], 32'd9);
        check_val("D_ch0_per0", per_hi[0][0], 32'd32);
        check_val("D_fr_cnt", fr_cnt, 32'd0);
        en_i = 1'b0;
        clear_stats();
        run_cycles(1);
        check_val("off_pwm", {28'd0, pwm_o}, 32'd0);
        check_val("off_frame", {31'd0, frame_o}, 32'd0);
        set_cfg(24'hFF_FFFF, 24'h01_8001, 24'h08_000F, 24'hC0_0000);
        run_cycles(3);
        check_val("off_hi3", hi_cnt[3], 32'd0);

        // Frame E: restart from en_i, new cfg applied immediately, no start pulse.
        en_i = 1'b1;
        clear_stats();
        run_cycles(4096);
        check_val("E_ch0_frame", hi_cnt[0], 32'd3072);
        check_val("E_ch0_first", {31'd0, pwm0_first}, 32'd1);
        check_val("E_ch1_frame", hi_cnt[1], 32'd132);
        check_val("E_ch3_frame", hi_cnt[3], 32'd4096);
        check_val("E_fr_first", {31'd0, fr_first}, 32'd0);
        check_val("E_fr_cnt", fr_cnt, 32'd1);
        check_val("E_fr_last", {31'd0, fr_last}, 32'd1);

        // Reset pulsed for 2 cycles mid-frame with en_i held high.
        clear_stats();
        run_cycles(1000);
        check_val("F_fr_cnt", fr_cnt, 32'd0);
        rst_i = 1'b1;
        clear_stats();
        run_cycles(2);
        check_val("R_hi3", hi_cnt[3], 32'd0);
        check_val("R_fr_cnt", fr_cnt, 32'd0);
        rst_i = 1'b0;
        clear_stats();
        run_cycles(4096);
        check_val("R_ch0_frame", hi_cnt[0], 32'd3072);
        check_val("R_ch0_per0", per_hi[0][0], 32'd192);
        check_val("R_ch1_per0", per_hi[1][0], 32'd9);
        check_val("R_fr_first", {31'd0, fr_first}, 32'd0);
        check_val("R_fr_cnt", fr_cnt, 32'd1);
        check_val("R_fr_last", {31'd0, fr_last}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
